ascii_bcd_assembler: RTL

//  Upstream feeder for BCD_to_binary_converter: turns an ASCII byte stream (UART RX / keypad) into
//  a right-aligned packed-BCD word. Digits shift in MS-digit first; BS edits, CR/LF commits, ESC aborts.

---
 rtl/ascii_bcd_pkg.sv | 27 ++
 rtl/ascii_char_classifier.sv | 28 ++
 rtl/ascii_bcd_assembler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ascii_bcd_pkg.sv
// Shared constants and types for the ASCII-to-packed-BCD line assembler.
package ascii_bcd_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_BS   = 8'h08;
    localparam logic [7:0] ASCII_DEL  = 8'h7F;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ESC  = 8'h1B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CH_DIGIT     = 3'd0,
        CH_BACKSPACE = 3'd1,
        CH_COMMIT    = 3'd2,
        CH_ABORT     = 3'd3,
        CH_OTHER     = 3'd4
    } char_class_t;

endpackage

// File: rtl/ascii_char_classifier.sv
// Combinational byte classifier: maps an ASCII byte to its editing role and digit value.
module ascii_char_classifier
    import ascii_bcd_pkg::*;
(
    input  logic [7:0]  data_i,
    output char_class_t char_class_o,
    output logic [3:0]  nibble_o
);

    assign nibble_o = data_i[3:0];

    // Decode the byte into one of the five editing classes
    always_comb begin
        char_class_o = CH_OTHER;
        if (data_i >= ASCII_ZERO && data_i <= ASCII_NINE) begin
            char_class_o = CH_DIGIT;
        end else if (data_i == ASCII_BS || data_i == ASCII_DEL) begin
            char_class_o = CH_BACKSPACE;
        end else if (data_i == ASCII_CR || data_i == ASCII_LF) begin
            char_class_o = CH_COMMIT;
        end else if (data_i == ASCII_ESC) begin
            char_class_o = CH_ABORT;
        end else begin
            char_class_o = CH_OTHER;
        end
    end

endmodule

// File: rtl/ascii_bcd_assembler.sv
// Assembles an ASCII digit stream into a right-aligned packed-BCD word offered on valid/ready.
module ascii_bcd_assembler
    import ascii_bcd_pkg::*;
#(
    parameter int DIGITS = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [7:0]                 data_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    output logic [4*DIGITS-1:0]        BCD_o,
    output logic                       BCD_valid_o,
    input  logic                       BCD_ready_i,
    output logic [$clog2(DIGITS+1)-1:0] digit_count_o,
    output logic                       error_o
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DIGITS);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
    localparam logic [4*DIGITS-1:0] BCD_ZERO = '0;

    char_class_t         class_s;
    logic [3:0]          nibble_s;
    state_t              state_r, state_s;
    logic [4*DIGITS-1:0] bcd_r, bcd_s;
    logic [CW-1:0]       count_r, count_s;
    logic                valid_r, valid_s;
    logic                error_r, error_s;
    logic                ready_r, ready_s;
    logic                accept_s;
    logic                take_s;

    ascii_char_classifier u_classifier (
        .data_i       (data_i),
        .char_class_o (class_s),
        .nibble_o     (nibble_s)
    );

    assign accept_s = data_valid_i && ready_r;
    assign take_s   = valid_r && BCD_ready_i;

    // Next-state and datapath update for one accepted byte or consumer handshake
    always_comb begin
        state_s = state_r;
        bcd_s   = bcd_r;
        count_s = count_r;
        valid_s = valid_r;
        error_s = error_r;
        if (take_s) begin
            state_s = IDLE;
            bcd_s   = BCD_ZERO;
            count_s = COUNT_ZERO;
            valid_s = 1'b0;
        end else if (accept_s) begin
            case (class_s)
                CH_DIGIT: begin
                    if (state_r == ERROR) begin
                        state_s = ERROR;
                    end else if (count_r < COUNT_MAX) begin
                        bcd_s   = {bcd_r[4*DIGITS-5:0], nibble_s};
                        count_s = count_r + COUNT_ONE;
                        state_s = ENTRY;
                    end else begin
                        state_s = ERROR;
                        error_s = 1'b1;
                    end
                end
                CH_BACKSPACE: begin
                    if (state_r != ERROR && count_r != COUNT_ZERO) begin
                        bcd_s   = {4'h0, bcd_r[4*DIGITS-1:4]};
                        count_s = count_r - COUNT_ONE;
                        state_s = (count_r == COUNT_ONE) ? IDLE : ENTRY;
                    end else begin
                        state_s = state_r;
                    end
                end
                CH_COMMIT: begin
                    if (state_r == ENTRY) begin
                        state_s = HOLD;
                        valid_s = 1'b1;
                    end else if (state_r == ERROR) begin
                        state_s = IDLE;
                        bcd_s   = BCD_ZERO;
                        count_s = COUNT_ZERO;
                        error_s = 1'b0;
                    end else begin
                        state_s = state_r;
                    end
                end
                CH_ABORT: begin
                    state_s = IDLE;
                    bcd_s   = BCD_ZERO;
                    count_s = COUNT_ZERO;
                    error_s = 1'b0;
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        // Bytes are refused only while a committed word waits for its consumer
        ready_s = (state_s != HOLD);
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            bcd_r   <= BCD_ZERO;
            count_r <= COUNT_ZERO;
            valid_r <= 1'b0;
            error_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            bcd_r   <= bcd_s;
            count_r <= count_s;
            valid_r <= valid_s;
            error_r <= error_s;
            ready_r <= ready_s;
        end
    end

    assign data_ready_o  = ready_r;
    assign BCD_o         = bcd_r;
    assign BCD_valid_o   = valid_r;
    assign digit_count_o = count_r;
    assign error_o       = error_r;

endmodule
